// File: rtl/parity_frame_tx_if.sv
// Word handshake between a producer core and parity_frame_tx.
// The producer drives the master side and the framer sits on the slave side.
interface parity_frame_tx_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             parity_odd;

    modport master (output in_data, output in_valid, output parity_odd, input in_ready);
    modport slave  (input in_data, input in_valid, input parity_odd, output in_ready);
endinterface

// File: rtl/parity_frame_tx.sv
// Serial parity framer: accepts a word, sends {word, parity} MSB-first on one line.
// Optional macro STOP_BIT_EN appends a high stop bit after the parity bit.
module parity_frame_tx #(
    parameter int WIDTH        = 32,
    parameter int CLKS_PER_BIT = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    parity_frame_tx_if.slave s_if,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             parity_bit,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

`ifdef STOP_BIT_EN
    localparam state_t FINAL_STATE = S_STOP;
`else
    localparam state_t FINAL_STATE = S_PARITY;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic [CW-1:0]    r_clk_cnt;
    logic             r_parity;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_in_ready;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_frame_cnt;

    state_t           w_state_nx;
    logic [WIDTH-1:0] w_shift_nx;
    logic [WIDTH-1:0] w_shifted;
    logic [BW-1:0]    w_bit_nx;
    logic [CW-1:0]    w_clk_nx;
    logic             w_parity_nx;
    logic             w_ser_out_nx;
    logic             w_ser_valid_nx;
    logic             w_in_ready_nx;
    logic             w_done_nx;
    logic             w_last_clk;

    assign w_shifted  = r_shift << 1;
    assign w_last_clk = (r_clk_cnt == CLK_LAST);

    always_comb begin
        w_state_nx     = r_state;
        w_shift_nx     = r_shift;
        w_bit_nx       = r_bit_cnt;
        w_clk_nx       = r_clk_cnt;
        w_parity_nx    = r_parity;
        w_ser_out_nx   = r_ser_out;
        w_ser_valid_nx = r_ser_valid;
        w_in_ready_nx  = r_in_ready;

        case (r_state)
            S_IDLE: begin
                if (s_if.in_valid && r_in_ready) begin
                    w_state_nx     = S_DATA;
                    w_shift_nx     = s_if.in_data;
                    w_bit_nx       = '0;
                    w_clk_nx       = '0;
                    w_parity_nx    = (^s_if.in_data) ^ s_if.parity_odd;
                    w_ser_out_nx   = s_if.in_data[WIDTH-1];
                    w_ser_valid_nx = 1'b1;
                    w_in_ready_nx  = 1'b0;
                end
            end
            S_DATA: begin
                if (w_last_clk) begin
                    w_clk_nx = '0;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nx   = S_PARITY;
                        w_ser_out_nx = r_parity;
                    end else begin
                        w_bit_nx     = r_bit_cnt + BW'(1);
                        w_shift_nx   = w_shifted;
                        w_ser_out_nx = w_shifted[WIDTH-1];
                    end
                end else begin
                    w_clk_nx = r_clk_cnt + CW'(1);
                end
            end
            S_PARITY: begin
                if (w_last_clk) begin
                    w_clk_nx = '0;
`ifdef STOP_BIT_EN
                    w_state_nx   = S_STOP;
                    w_ser_out_nx = 1'b1;
`else
                    w_state_nx     = S_IDLE;
                    w_ser_out_nx   = 1'b1;
                    w_ser_valid_nx = 1'b0;
                    w_in_ready_nx  = 1'b1;
`endif
                end else begin
                    w_clk_nx = r_clk_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (w_last_clk) begin
                    w_clk_nx       = '0;
                    w_state_nx     = S_IDLE;
                    w_ser_out_nx   = 1'b1;
                    w_ser_valid_nx = 1'b0;
                    w_in_ready_nx  = 1'b1;
                end else begin
                    w_clk_nx = r_clk_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nx     = S_IDLE;
                w_ser_out_nx   = 1'b1;
                w_ser_valid_nx = 1'b0;
                w_in_ready_nx  = 1'b1;
            end
        endcase

        // Registered pulse: raise frame_done on the edge entering the final bit's last cycle.
        w_done_nx = (w_state_nx == FINAL_STATE) && (w_clk_nx == CLK_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_clk_cnt    <= '0;
            r_parity     <= 1'b0;
            r_ser_out    <= 1'b1;
            r_ser_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_shift      <= w_shift_nx;
            r_bit_cnt    <= w_bit_nx;
            r_clk_cnt    <= w_clk_nx;
            r_parity     <= w_parity_nx;
            r_ser_out    <= w_ser_out_nx;
            r_ser_valid  <= w_ser_valid_nx;
            r_in_ready   <= w_in_ready_nx;
            r_frame_done <= w_done_nx;
            if (w_done_nx) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    assign s_if.in_ready = r_in_ready;
    assign ser_out       = r_ser_out;
    assign ser_valid     = r_ser_valid;
    assign parity_bit    = r_parity;
    assign frame_done    = r_frame_done;
    assign frame_cnt     = r_frame_cnt;
endmodule
